uplink_bus_arbiter: RTL

- Shares the single uplink word channel into the terminal SPI bridge (TR_IN / ADDR_IN / DATA_IN, back-pressured by TR_IN_BUSY) between N producers, e.g. receiver sample collector, GPS status reporter and probe-status reporter.
- Round-robin arbitration; a grant is held for a whole burst so that packets stay contiguous.
- Starved bursts are aborted after a timeout.
- Sits in the TR_CLK (50 MHz) domain between the producers and the terminal block.

---
 rtl/uplink_bus_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uplink_bus_arbiter.sv
// uplink_bus_arbiter
//   Shares the single uplink word channel into the terminal SPI bridge between
//   N producers. Arbitration is round-robin and a grant is held for a whole
//   burst so that packets stay contiguous. A burst is released on LAST, or on
//   MAX_BURST words, or when it is aborted because the owner stopped presenting
//   words for TIMEOUT cycles.
//
//   Ports
//     CLK, RESET          clock, synchronous active-high reset
//     REQ_VALID/ADDR/DATA/LAST  per-requester word (slices of 16/32 bits)
//     REQ_ACK             one-cycle pulse, requester's word taken
//     GRANT               one-hot current owner, 0 when idle
//     TR_IN, ADDR_IN, DATA_IN   word strobe and word to the terminal
//     TR_IN_BUSY          terminal back-pressure
//     ABORT               one-cycle pulse, owner's burst cut by timeout
module uplink_bus_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BURST = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N-1:0]    REQ_VALID,
    input  logic [16*N-1:0] REQ_ADDR,
    input  logic [32*N-1:0] REQ_DATA,
    input  logic [N-1:0]    REQ_LAST,
    output logic [N-1:0]    REQ_ACK,
    output logic [N-1:0]    GRANT,
    output logic            TR_IN,
    output logic [15:0]     ADDR_IN,
    output logic [31:0]     DATA_IN,
    input  logic            TR_IN_BUSY,
    output logic            ABORT
);
    localparam int              IW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [15:0]     BURST_MAX = 16'(MAX_BURST);
    localparam logic [15:0]     STALL_MAX = 16'(TIMEOUT);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] owner, owner_nx;
    logic [IW-1:0] rr_ptr, rr_ptr_nx;
    logic [15:0]   burst_cnt, burst_cnt_nx;
    logic [15:0]   stall_cnt, stall_cnt_nx;
    logic          rel, rel_nx;
    logic [N-1:0]  ack_nx, grant_nx;
    logic          tr_nx, abort_nx;
    logic [15:0]   addr_nx;
    logic [31:0]   data_nx;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;

    logic [15:0]   addr_arr [N];
    logic [31:0]   data_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign addr_arr[i] = REQ_ADDR[16*i +: 16];
        assign data_arr[i] = REQ_DATA[32*i +: 32];
    end

    // Round-robin pick: first requester after rr_ptr, wrapping; rr_ptr itself
    // is searched last, so the previous owner has lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(rr_ptr) + k) % N);
            if (!pick_found && REQ_VALID[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        rr_ptr_nx    = rr_ptr;
        burst_cnt_nx = burst_cnt;
        stall_cnt_nx = stall_cnt;
        rel_nx       = rel;
        grant_nx     = GRANT;
        ack_nx       = '0;
        tr_nx        = 1'b0;
        abort_nx     = 1'b0;
        addr_nx      = ADDR_IN;
        data_nx      = DATA_IN;
        unique case (state)
            IDLE: begin
                grant_nx = '0;
                if (pick_found) begin
                    owner_nx     = pick_idx;
                    grant_nx     = N'(1) << pick_idx;
                    burst_cnt_nx = '0;
                    stall_cnt_nx = '0;
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                if (REQ_VALID[owner] && !TR_IN_BUSY) begin
                    tr_nx        = 1'b1;
                    ack_nx       = N'(1) << owner;
                    addr_nx      = addr_arr[owner];
                    data_nx      = data_arr[owner];
                    burst_cnt_nx = burst_cnt + 16'd1;
                    stall_cnt_nx = '0;
                    // LAST on the MAX_BURST-th word is still one release.
                    rel_nx       = REQ_LAST[owner] || (burst_cnt + 16'd1 == BURST_MAX);
                    state_nx     = GAP;
                end else if (stall_cnt + 16'd1 == STALL_MAX) begin
                    if (!REQ_VALID[owner]) begin
                        abort_nx  = 1'b1;
                        grant_nx  = '0;
                        rr_ptr_nx = owner;
                        state_nx  = IDLE;
                    end
                    // Stalled only by the terminal: hold the counter one
                    // short of the limit so a later VALID drop aborts at once.
                end else begin
                    stall_cnt_nx = stall_cnt + 16'd1;
                end
            end
            GAP: begin
                if (rel) begin
                    grant_nx  = '0;
                    rr_ptr_nx = owner;
                    state_nx  = IDLE;
                end else begin
                    state_nx  = ISSUE;
                end
            end
            default: begin
                grant_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= LAST_IDX;
            burst_cnt <= '0;
            stall_cnt <= '0;
            rel       <= 1'b0;
            REQ_ACK   <= '0;
            GRANT     <= '0;
            TR_IN     <= 1'b0;
            ADDR_IN   <= '0;
            DATA_IN   <= '0;
            ABORT     <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            rr_ptr    <= rr_ptr_nx;
            burst_cnt <= burst_cnt_nx;
            stall_cnt <= stall_cnt_nx;
            rel       <= rel_nx;
            REQ_ACK   <= ack_nx;
            GRANT     <= grant_nx;
            TR_IN     <= tr_nx;
            ADDR_IN   <= addr_nx;
            DATA_IN   <= data_nx;
            ABORT     <= abort_nx;
        end
    end

endmodule
